// File: rtl/core_pkg.sv
// Shared core definitions: opcode classes, 2-bit counter encodings,
// predictor FSM states and the BTB update command set.
package core_pkg;

    // instr[6:2] encodings of control-transfer instructions
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    // 2-bit saturating counter encodings; bit 1 is the taken prediction
    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    // Update commands; the memory resolves hit/miss on the write index itself
    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,
        UPD_BR    = 2'd1,   // conditional branch resolve
        UPD_JMP   = 2'd2,   // jal/jalr: allocate or overwrite as strongly taken
        UPD_ALIAS = 2'd3    // non-control instruction: drop the entry if it hits
    } btb_upd_e;

    // Saturating +/-1 step of a 2-bit counter
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up) return (c == CTR_ST)  ? c : c + 2'd1;
        else    return (c == CTR_SNT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_mem.sv
// Direct-mapped BTB + counter storage: async lookup read, synchronous
// command-driven write, and a clear port used by the init sweep.
module btb_mem
    import core_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic              i_clk,
    // lookup port
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [31:0]       o_rd_target,
    output logic [1:0]        o_rd_ctr,
    // init clear port (has priority over updates)
    input  logic              i_clr,
    input  logic [IDX_W-1:0]  i_clr_idx,
    // update port
    input  btb_upd_e          i_upd,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [31:0]       i_wr_target,
    input  logic              i_wr_taken
);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic wr_hit;

    assign o_rd_valid  = valid_q[i_rd_idx];
    assign o_rd_tag    = tag_q[i_rd_idx];
    assign o_rd_target = target_q[i_rd_idx];
    assign o_rd_ctr    = ctr_q[i_rd_idx];

    // Hit on the update side is evaluated against pre-edge contents
    assign wr_hit = valid_q[i_wr_idx] && (tag_q[i_wr_idx] == i_wr_tag);

    // Sweep clear or one table update per cycle
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            valid_q[i_clr_idx] <= 1'b0;
            ctr_q[i_clr_idx]   <= CTR_WNT;
        end else begin
            case (i_upd)
                UPD_BR: begin
                    if (wr_hit) begin
                        ctr_q[i_wr_idx] <= ctr_step(ctr_q[i_wr_idx], i_wr_taken);
                        if (i_wr_taken) target_q[i_wr_idx] <= i_wr_target;
                    end else if (i_wr_taken) begin
                        valid_q[i_wr_idx]  <= 1'b1;
                        tag_q[i_wr_idx]    <= i_wr_tag;
                        target_q[i_wr_idx] <= i_wr_target;
                        ctr_q[i_wr_idx]    <= CTR_WT;
                    end
                end
                UPD_JMP: begin
                    valid_q[i_wr_idx]  <= 1'b1;
                    tag_q[i_wr_idx]    <= i_wr_tag;
                    target_q[i_wr_idx] <= i_wr_target;
                    ctr_q[i_wr_idx]    <= CTR_ST;
                end
                UPD_ALIAS: begin
                    if (wr_hit) valid_q[i_wr_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Fetch-side branch predictor and redirect controller: BTB lookup for the
// fetch PC, mispredict detection on EX resolve, registered flush/redirect,
// and a post-reset sweep that clears the tables.
module branch_predict_ctrl
    import core_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    output logic        o_ready,
    input  logic        i_stall,
    input  logic        i_ex_valid,
    input  logic [4:0]  i_ex_opcode,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_branch_en,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic        o_flush,
    output logic [31:0] o_redirect_pc
);

    localparam int TAG_W = 30 - IDX_W;

    if (ENTRIES < 4 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("branch_predict_ctrl: ENTRIES must be a power of 2 and >= 4");
    end

    bp_state_e        state_q;
    logic [IDX_W-1:0] sweep_idx_q;
    logic             ready_q;
    logic             flush_q;
    logic [31:0]      redirect_q;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_target;
    logic [1:0]       rd_ctr;

    logic             run;
    logic             lu_hit;
    logic             ex_fire;
    logic             is_br, is_jmp, is_ctrl;
    logic             act_taken;
    logic             mp;
    logic [31:0]      redirect_d;
    btb_upd_e         upd;
    logic             unused_pc_lsb;

    assign unused_pc_lsb = ^i_if_pc[1:0];
    assign run = (state_q == ST_RUN);

    btb_mem #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_btb (
        .i_clk       (i_clk),
        .i_rd_idx    (i_if_pc[IDX_W+1:2]),
        .o_rd_valid  (rd_valid),
        .o_rd_tag    (rd_tag),
        .o_rd_target (rd_target),
        .o_rd_ctr    (rd_ctr),
        .i_clr       (state_q == ST_INIT),
        .i_clr_idx   (sweep_idx_q),
        .i_upd       (upd),
        .i_wr_idx    (i_ex_pc[IDX_W+1:2]),
        .i_wr_tag    (i_ex_pc[31:IDX_W+2]),
        .i_wr_target (i_ex_target),
        .i_wr_taken  (act_taken)
    );

    // Zero-latency fetch lookup, forced quiet outside RUN
    always_comb begin
        lu_hit        = run && rd_valid && (rd_tag == i_if_pc[31:IDX_W+2]);
        o_pred_taken  = lu_hit && rd_ctr[1];
        o_pred_target = o_pred_taken ? rd_target : 32'd0;
    end

    // EX resolve: classify, detect mispredict, pick redirect and table command
    always_comb begin
        ex_fire    = run && i_ex_valid && !i_stall;
        is_br      = (i_ex_opcode == OPC_BRANCH);
        is_jmp     = (i_ex_opcode == OPC_JAL) || (i_ex_opcode == OPC_JALR);
        is_ctrl    = is_br || is_jmp;
        // a non-control instruction never actually redirects
        act_taken  = is_ctrl && i_ex_branch_en;
        mp         = (act_taken != i_ex_pred_taken) ||
                     (act_taken && (i_ex_target != i_ex_pred_target));
        redirect_d = act_taken ? i_ex_target : i_ex_pc + 32'd4;
        upd        = UPD_NONE;
        if (ex_fire) begin
            if (is_br)       upd = UPD_BR;
            else if (is_jmp) upd = UPD_JMP;
            else             upd = UPD_ALIAS;
        end
    end

    // Control FSM: init sweep, then run with registered flush/redirect
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_INIT;
            sweep_idx_q <= '0;
            ready_q     <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= 32'd0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    flush_q     <= 1'b0;
                    sweep_idx_q <= sweep_idx_q + 1'b1;
                    if (sweep_idx_q == IDX_W'(ENTRIES - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    flush_q <= ex_fire && mp;
                    if (ex_fire && mp) redirect_q <= redirect_d;
                end
            endcase
        end
    end

    assign o_ready       = ready_q;
    assign o_flush       = flush_q;
    assign o_redirect_pc = redirect_q;

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Fetch-side branch predictor and redirect controller for the RV32 core.
- Front end: a direct-mapped branch target buffer (BTB) plus 2-bit saturating counters that predict taken/target for the fetch PC.
- Back end: consumes the execute-stage branch decision (branch unit output) and issues a registered flush/redirect on mispredict.
- Trains the tables and clears itself with a sequential init sweep after reset.

Parameters:
- ENTRIES, 64, BTB/BHT entry count; must be a power of 2 and at least 4.
- IDX_W, $clog2(ENTRIES), index width.

Ports:
- i_clk  input  1  core clock
- i_rst  input  1  synchronous active-high reset
- i_if_pc  input  32  fetch PC, word aligned
- o_pred_taken  output  1  predict taken for i_if_pc (combinational)
- o_pred_target  output  32  predicted target; 0 when not taken
- o_ready  output  1  table init complete
- i_stall  input  1  pipeline stall; EX stage frozen
- i_ex_valid  input  1  valid instruction in EX
- i_ex_opcode  input  5  instr[6:2] of EX instruction
- i_ex_pc  input  32  PC of EX instruction
- i_ex_branch_en  input  1  actual taken, from branch unit
- i_ex_target  input  32  computed target address
- i_ex_pred_taken  input  1  prediction piped with the instruction
- i_ex_pred_target  input  32  predicted target piped with the instruction
- o_flush  output  1  one-cycle flush of IF/ID
- o_redirect_pc  output  32  fetch PC to load when o_flush is high

Behaviour:
- Clock and reset: one clock (i_clk); reset is synchronous and active-high (i_rst).
- Address mapping:
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
- Entry contents: valid, tag, target[31:0], ctr[1:0].
- FSM states: INIT, RUN.
- Reset (including mid-operation):
  - FSM goes to INIT with sweep index 0.
  - o_flush=0, o_redirect_pc=0, o_ready=0.
  - o_pred_taken=0 and o_pred_target=0 while not in RUN.
- INIT:
  - Each cycle clears valid[idx] and sets ctr[idx]=2'b01.
  - After idx=ENTRIES-1, moves to RUN; o_ready=1 from the next cycle.
  - The sweep takes exactly ENTRIES cycles after i_rst deasserts.
  - EX inputs are ignored and no flush is generated.
- Lookup (RUN, combinational, zero latency):
  - hit = valid & tag match.
  - o_pred_taken = hit & ctr[1].
  - o_pred_target = o_pred_taken ? target : 0.
- Control-instruction classes:
  - branch = opcode 5'b11000
  - jal = 5'b11011
  - jalr = 5'b11001
- Resolve/update occurs only when RUN & i_ex_valid & !i_stall. A stall holds the event; it is processed once when the stall releases.
- Mispredict (mp) is true when either:
  - i_ex_branch_en != i_ex_pred_taken, or
  - i_ex_branch_en & (i_ex_target != i_ex_pred_target).
- Non-control instruction with i_ex_pred_taken=1 (alias): mp=1 and actual taken=0.
- On mp, registered at the next edge:
  - o_flush=1 for exactly one cycle.
  - o_redirect_pc = taken ? i_ex_target : i_ex_pc+4 (32-bit wrap).
  - Otherwise o_flush=0.
- Table update at the same edge, by case:
  - Conditional branch, hit: ctr saturating ±1 (3 stays 3, 0 stays 0); if taken, target is rewritten.
  - Conditional branch, miss, taken: allocate; valid=1, tag, target, ctr=2'b10.
  - Conditional branch, miss, not taken: no write.
  - jal/jalr: allocate or overwrite; ctr=2'b11, target=i_ex_target.
  - Alias (non-control instruction that hit): valid cleared.
- Same-cycle read/write to one index: the lookup sees the pre-update contents; the write lands at the edge.
- Back-to-back mispredicts: each produces its own one-cycle flush. The pipeline must deliver EX valid=0 in the cycle after a flush; a second flush in consecutive cycles is legal and the latest redirect wins.

Decomposition:
- Shared package core_pkg holds:
  - OPC_BRANCH=5'b11000, OPC_JAL=5'b11011, OPC_JALR=5'b11001 (also used by the branch unit and decoder)
  - counter encodings CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3
  - FSM state constants
- One sub-module, btb_mem:
  - holds valid/tag/target/ctr arrays
  - one asynchronous read port, one synchronous write port, plus a clear port used by the INIT sweep
- Control FSM and mispredict logic stay in branch_predict_ctrl.

Test Plan (ENTRIES=64):
1. Reset init: pulse i_rst 1 cycle -> o_ready=0 for exactly 64 cycles, then 1; o_pred_taken=0 for every i_if_pc throughout; assert i_rst at cycle 30 of the sweep -> sweep restarts, o_ready rises 64 cycles after that release.
2. Cold taken branch: EX branch pc=0x100, taken, target=0x80, pred_taken=0 -> next cycle o_flush=1, o_redirect_pc=0x80, one cycle only; then i_if_pc=0x100 -> o_pred_taken=1, o_pred_target=0x80.
3. Counter hysteresis: the same branch resolved not taken once (pred_taken=1) -> flush, redirect 0x104, ctr=01; lookup predicts not taken; two taken resolves -> ctr=11; one not-taken -> still predicts taken.
4. Target mismatch: jalr pc=0x200, pred 0x300, actual 0x340 -> flush, redirect 0x340; lookup 0x200 -> target 0x340.
5. Alias and stall: entry for 0x100 hit by non-control instruction pc=0x100 with pred_taken=1, i_stall=1 for 3 cycles -> no flush during stall; flush once after release, redirect 0x104; entry invalidated.
6. Wrap: branch at pc=0xFFFFFFFC not taken with pred_taken=1 -> redirect 0x00000000; aliasing pc 0x100 vs 0x200 (same index, different tag) -> miss, no false prediction.
